// File: rtl/lcd_fb_reader.sv
`default_nettype none
// ============================================================================
// Module : lcd_fb_reader
// Brief  : Sequential frame-buffer scanner, BRAM -> 2-entry FIFO -> pixel stream
// Rev    : 1.0
// ============================================================================
module lcd_fb_reader #(
  parameter int WIDTH = 8,
  parameter int H_RES = 160,
  parameter int V_RES = 80,
  parameter int LEN   = H_RES * V_RES,
  parameter int AW    = $clog2(LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             mem_req,
  output logic [AW-1:0]    mem_addr,
  input  logic [WIDTH-1:0] mem_dout,
  output logic [WIDTH-1:0] pix_data,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             pix_eol,
  output logic             pix_last,
  output logic             frame_done
);

  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [XW-1:0] X_MAX = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(V_RES - 1);
  localparam logic [AW-1:0] A_MAX = AW'(LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t           state_q;
  logic [AW-1:0]    rd_addr_q;
  logic             inflight_q;
  logic [1:0]       fifo_cnt_q;
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [WIDTH-1:0] fifo_q [2];
  logic [XW-1:0]    x_q;
  logic [YW-1:0]    y_q;
  logic             done_q;

  logic       pop;
  logic       push;
  logic       issue;
  logic       last_pop;
  logic       flush;
  logic [2:0] occ;

  assign pop      = pix_valid & pix_ready;
  assign push     = inflight_q;
  // Words held or in flight must stay within the two FIFO slots after this cycle's pop.
  assign occ      = {1'b0, fifo_cnt_q} + {2'b00, inflight_q};
  assign issue    = (state_q == S_RUN) && (occ < (3'd2 + {2'b00, pop}));
  assign last_pop = (state_q == S_DRAIN) && pop && (fifo_cnt_q == 2'd1) && !inflight_q;
  assign flush    = abort && (state_q != S_IDLE);

  assign busy       = (state_q != S_IDLE);
  assign mem_req    = busy;
  assign mem_addr   = rd_addr_q;
  assign pix_valid  = (fifo_cnt_q != 2'd0);
  assign pix_data   = fifo_q[rd_ptr_q];
  assign pix_eol    = pix_valid && (x_q == X_MAX);
  assign pix_last   = pix_eol && (y_q == Y_MAX);
  assign frame_done = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rd_addr_q  <= '0;
      inflight_q <= 1'b0;
      fifo_cnt_q <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      x_q        <= '0;
      y_q        <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        // The frame_done cycle still refuses start so a new frame never overlaps the pulse.
        S_IDLE: begin
          if (start && !abort && !done_q) begin
            state_q   <= S_RUN;
            rd_addr_q <= '0;
          end
        end
        S_RUN: begin
          if (abort) begin
            state_q <= S_IDLE;
          end else if (issue && (rd_addr_q == A_MAX)) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (abort) begin
            state_q <= S_IDLE;
          end else if (last_pop) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (flush || (state_q == S_IDLE)) begin
        if (flush) begin
          inflight_q <= 1'b0;
          fifo_cnt_q <= 2'd0;
          wr_ptr_q   <= 1'b0;
          rd_ptr_q   <= 1'b0;
        end
        x_q <= '0;
        y_q <= '0;
      end else begin
        inflight_q <= issue;
        if (issue) begin
          rd_addr_q <= rd_addr_q + AW'(1);
        end
        if (push) begin
          fifo_q[wr_ptr_q] <= mem_dout;
          wr_ptr_q         <= ~wr_ptr_q;
        end
        if (pop) begin
          rd_ptr_q <= ~rd_ptr_q;
          if (x_q == X_MAX) begin
            x_q <= '0;
            y_q <= y_q + YW'(1);
          end else begin
            x_q <= x_q + XW'(1);
          end
        end
        fifo_cnt_q <= fifo_cnt_q + {1'b0, push} - {1'b0, pop};
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lcd_fb_reader.sv
`default_nettype none
// ============================================================================
// Module : tb_lcd_fb_reader
// Brief  : Self-checking bench, transaction-count model of the frame scanner
// Rev    : 1.0
// ============================================================================
module tb_lcd_fb_reader;

  localparam int WIDTH = 8;
  localparam int H_RES = 160;
  localparam int V_RES = 80;
  localparam int LEN   = H_RES * V_RES;
  localparam int AW    = $clog2(LEN);

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             pix_ready = 1'b0;
  logic             busy, mem_req, pix_valid, pix_eol, pix_last, frame_done;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_dout = '0;
  logic [WIDTH-1:0] pix_data;
  logic [WIDTH-1:0] mem [LEN];

  int total = 0;
  int bad   = 0;
  int ready_mode = 0;

  // model: issued / pushed / transferred word counts of the current frame
  bit m_act  = 1'b0;
  bit m_done = 1'b0;
  int mI = 0, mU = 0, mP = 0;
  int n_xfer = 0, n_eol = 0, n_last = 0, n_done = 0, n_busy = 0;

  always #5 clk = ~clk;

  lcd_fb_reader #(.WIDTH(WIDTH), .H_RES(H_RES), .V_RES(V_RES)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy), .mem_req(mem_req), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_eol(pix_eol), .pix_last(pix_last), .frame_done(frame_done)
  );

  always @(posedge clk) mem_dout <= (int'(mem_addr) < LEN) ? mem[mem_addr] : '0;

  always @(posedge clk) begin
    #1;
    pix_ready = (ready_mode == 2) ? 1'($urandom % 2) : (ready_mode == 1);
  end

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin : cmp
    logic vexp, pop, cur_done, iss;
    if (!rst_n) begin
      check("rst_busy", busy, 0);
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_valid", pix_valid, 0);
      check("rst_data", pix_data, 0);
      check("rst_eol_last", {pix_eol, pix_last}, 0);
      check("rst_done", frame_done, 0);
      m_act = 0; m_done = 0; mI = 0; mU = 0; mP = 0;
    end else begin
      vexp = m_act && (mU > mP);
      check("busy", busy, m_act);
      check("mem_req", mem_req, m_act);
      check("valid", pix_valid, vexp);
      check("frame_done", frame_done, m_done);
      check("occ_le_2", (int'(dut.fifo_cnt_q) + int'(dut.inflight_q)) <= 2, 1);
      if (m_act) check("mem_addr", mem_addr, mI);
      if (vexp) begin
        check("data", pix_data, mem[mP]);
        check("eol", pix_eol, (mP % H_RES) == H_RES - 1);
        check("last", pix_last, mP == LEN - 1);
      end else begin
        check("eol_idle", {pix_eol, pix_last}, 0);
      end
      if (busy) n_busy++;
      if (frame_done) n_done++;
      if (pix_valid && pix_ready) begin
        n_xfer++;
        if (pix_eol) n_eol++;
        if (pix_last) n_last++;
      end
      pop = vexp && pix_ready;
      cur_done = m_done;
      m_done = 0;
      if (m_act && abort) begin
        m_act = 0; mI = 0; mU = 0; mP = 0;
      end else if (m_act) begin
        iss = (mI < LEN) && ((mI - mP - int'(pop)) < 2);
        mU = mI;
        if (iss) mI++;
        if (pop) mP++;
        if (mP == LEN) begin
          m_act = 0; m_done = 1;
        end
      end else if (start && !abort && !cur_done) begin
        m_act = 1; mI = 0; mU = 0; mP = 0;
      end
    end
  end

  task automatic clear_stats();
    n_xfer = 0; n_eol = 0; n_last = 0; n_done = 0; n_busy = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c;
    c = 0;
    while (!frame_done && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("frame_done_seen", frame_done, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(input int budget);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!pix_valid && c < budget);
    check("first_valid_seen", pix_valid, 1);
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_xfers"}, n_xfer, LEN);
    check({tag, "_eols"}, n_eol, V_RES);
    check({tag, "_lasts"}, n_last, 1);
    check({tag, "_dones"}, n_done, 1);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    for (int i = 0; i < LEN; i++) mem[i] = WIDTH'(i % 16);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    // Full-rate frame with latency pins
    ready_mode = 1;
    repeat (2) @(posedge clk);
    #1 clear_stats();
    pulse_start();
    @(negedge clk);
    check("lat_c0_valid", pix_valid, 0);
    check("lat_c0_addr", mem_addr, 0);
    check("lat_c0_busy", busy, 1);
    @(negedge clk);
    check("lat_c1_valid", pix_valid, 0);
    check("lat_c1_addr", mem_addr, 1);
    @(negedge clk);
    check("lat_c2_valid", pix_valid, 1);
    check("lat_c2_data", pix_data, 0);
    wait_done(LEN + 20);
    check_frame("full");
    check("full_busy_cycles", n_busy, LEN + 2);
    repeat (5) @(posedge clk);
    #1 check("full_single_done", n_done, 1);

    // Random backpressure
    ready_mode = 2;
    #1 clear_stats();
    pulse_start();
    wait_done(LEN * 6);
    check_frame("rand");
    ready_mode = 1;
    repeat (4) @(posedge clk);

    // Long stall after the first valid, start while busy, start on frame_done cycle
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #1 clear_stats();
    pulse_start();
    wait_valid(10);
    check("stall_first_data", pix_data, 0);
    repeat (20) @(negedge clk);
    check("stall_addr", mem_addr, 2);
    check("stall_valid", pix_valid, 1);
    check("stall_data", pix_data, 0);
    pulse_start();
    ready_mode = 1;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!(pix_valid && pix_ready && pix_last) && c < LEN * 2);
    check("stall_last_seen", pix_valid && pix_ready && pix_last, 1);
    @(posedge clk); #1 start = 1'b1;
    @(negedge clk);
    check("fd_cycle_done", frame_done, 1);
    check("fd_cycle_busy", busy, 0);
    @(posedge clk); #1;
    check_frame("stall");
    clear_stats();
    @(negedge clk);
    check("fd_start_ignored", busy, 0);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("fd_plus1_accepted", busy, 1);

    // Abort at pixel 5000, then a fresh frame
    c = 0;
    while (n_xfer < 5000 && c < LEN * 2) begin
      @(posedge clk); #1;
      c++;
    end
    check("abort_reached_5000", n_xfer, 5000);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_valid", pix_valid, 0);
    repeat (6) @(negedge clk);
    check("abort_no_done", n_done, 0);
    @(posedge clk); #1 clear_stats();
    pulse_start();
    wait_valid(10);
    check("restart_data0", pix_data, 0);
    wait_done(LEN + 20);
    check_frame("restart");

    // Asynchronous reset mid-frame
    #1 clear_stats();
    pulse_start();
    repeat (100) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_busy", busy, 0);
    check("async_valid", pix_valid, 0);
    check("async_addr", mem_addr, 0);
    check("async_data", pix_data, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_valid", pix_valid, 0);
    check("post_rst_busy", busy, 0);

    // start together with abort in IDLE
    @(posedge clk); #1 start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("start_abort_idle", busy, 0);
    repeat (3) @(negedge clk);
    check("post_rst_no_done", n_done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lcd_fb_reader.md
Name: lcd_fb_reader

Overview:
Frame-buffer scanner that sits directly downstream of the single-port pixel BRAM (H_RES*V_RES words, 1-cycle registered read latency). On a start pulse it reads the buffer sequentially from address 0 to LEN-1. It hides the BRAM latency with a 2-entry output FIFO and streams pixels to the LCD serializer over a valid/ready handshake, with line and frame markers. While busy it owns the BRAM address port; the upstream arbiter muxes writers onto the port using mem_req.

Parameters:
WIDTH, 8, pixel word width; must match the BRAM WIDTH.
H_RES, 160, pixels per line.
V_RES, 80, lines per frame.
LEN, H_RES*V_RES (12800), total words read per frame.
AW, log2(LEN-1)+1 (14), address width; same rule as the BRAM addr port.

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  1-cycle request to scan one frame; ignored while busy
abort  in  1  synchronous; cancels the frame in progress
busy  out  1  high from the cycle after start is accepted until the frame ends or is aborted
mem_req  out  1  equals busy; tells the arbiter to route mem_addr to the BRAM
mem_addr  out  AW  BRAM read address
mem_dout  in  WIDTH  BRAM registered read data
pix_data  out  WIDTH  pixel value
pix_valid  out  1  pix_data is valid
pix_ready  in  1  consumer accepts; transfer = pix_valid & pix_ready
pix_eol  out  1  qualifies pix_data: last pixel of a line (x==H_RES-1)
pix_last  out  1  qualifies pix_data: pixel LEN-1
frame_done  out  1  1-cycle pulse after the last pixel transfers

Behaviour:
- Reset (rst_n low, async): state IDLE. busy=0, mem_req=0, mem_addr=0, pix_valid=0, pix_data=0, pix_eol=0, pix_last=0, frame_done=0. FIFO is empty and the inflight flag is cleared. Reset mid-frame discards all data. No frame_done is produced.
- States:
  - IDLE: start -> RUN, rd_addr=0.
  - RUN: issues reads. Moves to DRAIN at the edge where address LEN-1 is issued.
  - DRAIN: waits until the FIFO is empty and inflight=0 after the final transfer, then -> IDLE with a frame_done pulse.
- mem_addr = rd_addr, a registered counter.
- Issue condition: state RUN and (fifo_count + inflight - pop) < 2, where pop = pix_valid & pix_ready.
  - On issue: rd_addr increments and inflight is set for the next cycle.
  - Otherwise mem_addr holds; extra BRAM reads are harmless.
- When inflight=1, mem_dout is pushed into the FIFO at the end of that cycle. A push and a pop in the same cycle are legal.
- Latency: start sampled at edge N -> mem_addr=0 during cycle N..N+1 -> first pix_valid high after edge N+2.
- Throughput: with pix_ready held high, one pixel per clock, no bubbles, LEN+2 cycles from start to the last transfer.
- Handshake:
  - While pix_valid=1 and pix_ready=0, pix_data, pix_eol and pix_last hold stable.
  - pix_valid never drops without a transfer, except on abort or reset.
- Markers come from x/y counters advanced per transfer (x wraps at H_RES-1, y increments). pix_eol is 1 when x==H_RES-1; pix_last is 1 when x==H_RES-1 and y==V_RES-1.
- frame_done: pulses at the edge after the pix_last transfer. busy falls at that same edge, so start is accepted on the following cycle at the earliest.
- start while busy is ignored. start and abort asserted together in IDLE: abort wins, start is ignored.
- abort in RUN/DRAIN: next edge goes to IDLE, flushes the FIFO, clears inflight, pix_valid=0, no frame_done. A transfer coincident with abort still completes on the consumer side.
- Overflow is impossible by construction. The bench asserts fifo_count+inflight <= 2 at every cycle.

Test Plan:
- BRAM model preloaded mem[i]=i%16, pix_ready=1, start pulse: 12800 transfers with values 0,1,…,15,0,…; pix_eol on transfers 159, 319, …; pix_last only on transfer 12799; frame_done exactly once, 1 cycle after it; busy high 12802 cycles.
- Random pix_ready (50%): pixel sequence identical to the previous case; pix_data stable during every stall; no lost or duplicated pixels; the invariant holds.
- pix_ready held low 20 cycles after the first valid: mem_addr stops at 2; after release, pixels 0,1,2,3… continue back-to-back.
- abort at pixel 5000, then start: no frame_done for the aborted frame; the new frame begins at pixel 0 (value 0) and completes normally.
- rst_n pulled low mid-frame (async, between edges): outputs go to reset values immediately; with no start after reset release, pix_valid stays 0.
- start pulsed during busy and on the frame_done cycle: both ignored; a start one cycle after frame_done is accepted.
